// File: rtl/mlp_layer_seq.sv
// -----------------------------------------------------------------------------
// mlp_layer_seq
//
// Sequential fully-connected MLP layer. It has N_IN signed fixed-point inputs
// and N_OUT neurons, and performs one multiply-accumulate per clock.
//
// Weights and biases live in a register memory that is written through a
// simple write port. The memory can be written only while the layer is idle.
// The memory layout is:
//   address j*N_IN + i     -> weight w[j][i]
//   address N_IN*N_OUT + j -> bias b[j]
//
// Each neuron computes
//   y[j] = sat((b[j] << FRAC + sum_i x[i]*w[j][i]) >>> FRAC)
// The arithmetic shift rounds toward minus infinity. sat() clamps the result
// to the signed DW-bit range.
//
// Configuration macro:
//   MLP_LAYER_RELU_EN - when defined, each stored result is max(0, sat(...)).
//                       Timing is the same in both modes.
//
// Ports:
//   CLK       in   1          clock, rising edge
//   reset     in   1          synchronous, active-high reset
//   start     in   1          start a computation (sampled only in IDLE)
//   in_flat   in   N_IN*DW    x[i] = in_flat[i*DW +: DW]
//   busy      out  1          registered, high while a computation is running
//   done      out  1          registered, one-cycle pulse when out_flat is final
//   out_flat  out  N_OUT*DW   y[j] = out_flat[j*DW +: DW]
//   wr_en     in   1          weight/bias write strobe (IDLE only)
//   wr_addr   in   AW         weight/bias address
//   wr_data   in   DW         weight/bias data
// -----------------------------------------------------------------------------
module mlp_layer_seq #(
    parameter  int N_IN  = 6,
    parameter  int N_OUT = 2,
    parameter  int DW    = 32,
    parameter  int FRAC  = 16,
    localparam int AW    = $clog2(N_IN * N_OUT + N_OUT)
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_IN*DW-1:0]    in_flat,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT*DW-1:0]   out_flat,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data
);

    localparam int N_W   = N_IN * N_OUT;          // number of weight words
    localparam int DEPTH = N_W + N_OUT;           // weights followed by biases
    localparam int ACC_W = 2 * DW + $clog2(N_IN + 1);
    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // Clamp limits, expressed at accumulator width so the comparison is exact.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic        [DW-1:0]    Y_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic        [DW-1:0]    Y_MIN   = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    state_t                   state;
    logic        [IW-1:0]     i;
    logic        [JW-1:0]     j;
    logic        [AW-1:0]     widx;      // runs through j*N_IN+i in MAC order
    logic signed [ACC_W-1:0]  acc;
    logic signed [DW-1:0]     x_reg [N_IN];
    logic signed [DW-1:0]     mem   [DEPTH];

    logic                     wr_ok;
    logic        [AW-1:0]     bias_addr;
    logic signed [DW-1:0]     bias_val;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [DW-1:0]     x_cur;
    logic signed [DW-1:0]     w_cur;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  shifted;
    logic        [DW-1:0]     sat_val;
    logic        [DW-1:0]     y_val;

    // NOTE: every signal assigned in always_comb gets a default value first.
    // This keeps every path assigned, so no latch is inferred.
    always_comb begin
        wr_ok = wr_en && (state == S_IDLE) && (wr_addr < AW'(DEPTH));

        // In IDLE the bias of neuron 0 is needed. In STORE the bias of the
        // next neuron is needed.
        bias_addr = AW'(N_W);
        if (state != S_IDLE) begin
            bias_addr = AW'(N_W) + AW'(j) + AW'(1);
        end

        // A bias-0 write on the start edge must take effect for that run.
        // Bypass the memory so the new value is used immediately.
        bias_val = mem[bias_addr];
        if (wr_ok && (wr_addr == AW'(N_W))) begin
            bias_val = wr_data;
        end
        bias_ext = ACC_W'(bias_val) <<< FRAC;

        x_cur = x_reg[i];
        w_cur = mem[widx];
        prod  = (2*DW)'(x_cur) * (2*DW)'(w_cur);

        shifted = acc >>> FRAC;
        sat_val = shifted[DW-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = Y_MAX;
        end else if (shifted < SAT_MIN) begin
            sat_val = Y_MIN;
        end

`ifdef MLP_LAYER_RELU_EN
        y_val = sat_val[DW-1] ? '0 : sat_val;
`else
        y_val = sat_val;
`endif
    end

    // NOTE: all state is updated with non-blocking assignments. Every register
    // then samples values from before the edge, whatever the statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_flat <= '0;
            i        <= '0;
            j        <= '0;
            widx     <= '0;
            acc      <= '0;
            for (int k = 0; k < N_IN; k++) begin
                x_reg[k] <= '0;
            end
            // NOTE: the coefficient memory is a register file and is cleared
            // on reset. An unloaded layer therefore computes well-defined zeros.
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            // busy and done are registered copies of the state. They lag the
            // state by one cycle, so busy also covers the done cycle.
            busy <= (state != S_IDLE);
            done <= (state == S_DONE);

            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_IN; k++) begin
                            x_reg[k] <= in_flat[k*DW +: DW];
                        end
                        i     <= '0;
                        j     <= '0;
                        widx  <= '0;
                        acc   <= bias_ext;
                        state <= S_MAC;
                    end
                end

                S_MAC: begin
                    acc  <= acc + ACC_W'(prod);
                    widx <= widx + AW'(1);
                    if (i == IW'(N_IN - 1)) begin
                        state <= S_STORE;
                    end else begin
                        i <= i + IW'(1);
                    end
                end

                S_STORE: begin
                    out_flat[j*DW +: DW] <= y_val;
                    if (j == JW'(N_OUT - 1)) begin
                        state <= S_DONE;
                    end else begin
                        // widx already points at w[j+1][0] because weights
                        // are stored in MAC order.
                        j     <= j + JW'(1);
                        i     <= '0;
                        acc   <= bias_ext;
                        state <= S_MAC;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_mlp_layer_seq
//
// Directed self-checking bench for mlp_layer_seq with the default parameters
// (6 inputs, 2 neurons, Q16.16 words). It checks the following:
//   - reset state
//   - an unloaded run
//   - the basic vectors
//   - a weight/bias write on the same edge as start
//   - positive and negative saturation
//   - reset in the middle of a run
//   - writes and start while busy
// The expected results follow MLP_LAYER_RELU_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mlp_layer_seq;

    localparam int N_IN  = 6;
    localparam int N_OUT = 2;
    localparam int DW    = 32;
    localparam int FRAC  = 16;
    localparam int AW    = 4;
    localparam int LAT   = N_OUT * (N_IN + 1) + 1;

    logic                  CLK;
    logic                  reset;
    logic                  start;
    logic [N_IN*DW-1:0]    in_flat;
    logic                  busy;
    logic                  done;
    logic [N_OUT*DW-1:0]   out_flat;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;

    int n_vec;
    int n_bad;

`ifdef MLP_LAYER_RELU_EN
    localparam logic [31:0] Y1_BASIC = 32'h0000_0000;
    localparam logic [31:0] Y_NEG    = 32'h0000_0000;
`else
    localparam logic [31:0] Y1_BASIC = 32'hFFFF_8000;
    localparam logic [31:0] Y_NEG    = 32'h8000_0000;
`endif

    mlp_layer_seq #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .DW    (DW),
        .FRAC  (FRAC)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .in_flat  (in_flat),
        .busy     (busy),
        .done     (done),
        .out_flat (out_flat),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle. Outputs are then sampled
    // away from the edge.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick;
        wr_en   = 1'b0;
    endtask

    task automatic set_x_all(input logic [31:0] v);
        for (int k = 0; k < N_IN; k++) in_flat[k*DW +: DW] = v;
    endtask

    task automatic set_x_basic;
        for (int k = 0; k < N_IN; k++) in_flat[k*DW +: DW] = 32'((k + 1) << 16);
    endtask

    task automatic load_basic;
        for (int k = 0; k < N_IN; k++) wr(AW'(k), 32'h0001_0000);
        wr(AW'(N_IN), 32'h0000_8000);
        for (int k = 1; k < N_IN; k++) wr(AW'(N_IN + k), 32'h0);
        wr(AW'(12), 32'h0);
        wr(AW'(13), 32'hFFFF_0000);
    endtask

    task automatic load_all_w(input logic [31:0] v);
        for (int k = 0; k < N_IN * N_OUT; k++) wr(AW'(k), v);
        wr(AW'(12), 32'h0);
        wr(AW'(13), 32'h0);
    endtask

    // Pulse start and wait, within a bound, for the done pulse.
    // This checks the latency, busy timing and the single-cycle done.
    // A write that is set up beforehand commits on the start edge.
    task automatic run(input string tag);
        int lat;
        start = 1'b1;
        tick;                          // edge 0 samples start
        start = 1'b0;
        wr_en = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 60; k++) begin
            tick;
            if (k == 1) check({tag, "_busy_rise"}, 64'(busy), 64'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        tick;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n_done;
        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        in_flat = '0;

        // Reset held for 10 cycles with random activity on the inputs.
        for (int k = 0; k < 10; k++) begin
            in_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            start   = 1'($urandom);
            wr_en   = 1'($urandom);
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            tick;
        end
        reset = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out", out_flat, 64'h0);

        // An unloaded memory gives zeros, even with nonzero inputs.
        set_x_basic;
        run("unloaded");
        check("unloaded_out", out_flat, 64'h0);

        // Basic vectors.
        load_basic;
        run("basic");
        check("basic_out", out_flat, {Y1_BASIC, 32'h0015_0000});

        // Bias 0 written on the start edge: y0 becomes 21 + 2.
        wr_en   = 1'b1;
        wr_addr = AW'(12);
        wr_data = 32'h0002_0000;
        run("wr_start");
        check("wr_start_out", out_flat, {Y1_BASIC, 32'h0017_0000});

        // Positive saturation.
        set_x_all(32'h7FFF_0000);
        load_all_w(32'h7FFF_0000);
        run("sat_pos");
        check("sat_pos_out", out_flat, {32'h7FFF_FFFF, 32'h7FFF_FFFF});

        // Negative saturation.
        load_all_w(32'h8001_0000);
        run("sat_neg");
        check("sat_neg_out", out_flat, {Y_NEG, Y_NEG});

        // Reset during MAC: nonzero outputs are left over from the positive
        // case, which rules out a stale all-zero result.
        load_all_w(32'h7FFF_0000);
        run("pre_reset");
        start = 1'b1;
        tick;                          // edge 0
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick;
        reset = 1'b1;
        tick;                          // edge 5
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_out", out_flat, 64'h0);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            n_done += int'(done);
        end
        check("midrst_no_done", 64'(n_done), 64'd0);

        // Busy protection: a weight write and a second start during the run.
        set_x_basic;
        load_basic;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                wr_en   = 1'b1;
                wr_addr = AW'(0);
                wr_data = 32'h0;
                start   = 1'b1;
            end
            if (k == 6) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            tick;
            n_done += int'(done);
        end
        check("busy_one_done", 64'(n_done), 64'd1);
        check("busy_out", out_flat, {Y1_BASIC, 32'h0015_0000});
        run("busy_rerun");
        check("busy_rerun_out", out_flat, {Y1_BASIC, 32'h0015_0000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mlp_layer_seq.md
# mlp_layer_seq

Parametrised, sequential fully-connected MLP layer: N_IN signed fixed-point inputs, N_OUT neurons, one multiply-accumulate per clock. Weights and biases sit in an internal register memory loaded through a write port. A start/busy/done handshake drives computation. Multi-layer MLPs chain instances, wiring each layer's outputs to the next layer's inputs under a top-level sequencer. Generalises the fixed 6-input/2-output MLP to arbitrary width, depth and fraction format, with runtime-loadable weights and saturation.

## Interface
- N_IN, 6, inputs per neuron (≥1)
- N_OUT, 2, neurons in layer (≥1)
- DW, 32, data/weight/bias word width, signed two's complement
- FRAC, 16, fraction bits of the fixed-point format (0 ≤ FRAC < DW)
- Derived localparam AW = clog2(N_IN*N_OUT + N_OUT), memory address width

- CLK  in  1  clock, rising-edge active
- reset  in  1  synchronous, active-high reset
- start  in  1  request computation; sampled only in IDLE
- in_flat  in  N_IN*DW  inputs; x[i] = in_flat[i*DW +: DW]
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; results valid
- out_flat  out  N_OUT*DW  outputs; y[j] = out_flat[j*DW +: DW]
- wr_en  in  1  weight/bias write strobe
- wr_addr  in  AW  address j*N_IN+i = weight w[j][i]; N_IN*N_OUT+j = bias b[j]
- wr_data  in  DW  write data

## Operation
- Reset: state IDLE, busy=0, done=0, all out_flat words 0, all weight and bias words 0, counters 0.
- Writes: accepted only in IDLE with wr_en=1 and wr_addr < N_IN*N_OUT+N_OUT. Writes out of range or while busy are ignored. Memory reads are combinational.
- FSM states: IDLE → MAC → STORE → (MAC … | DONE) → IDLE.
  - IDLE, start=1: latch in_flat into internal x regs; i=0, j=0; acc = b[0] sign-extended and shifted left by FRAC; go to MAC.
  - MAC: acc += x[i]*w[j][i] (full 2*DW signed product). If i=N_IN−1, go to STORE; else i++.
  - STORE: y[j] ← sat(acc >>> FRAC). If j=N_OUT−1, go to DONE. Otherwise j++, i=0, acc = b[j+1]<<FRAC, go to MAC.
  - DONE: done=1 for this cycle only; go to IDLE.
- Arithmetic:
  - acc width 2*DW + clog2(N_IN+1); it cannot overflow.
  - The shift is arithmetic, so truncation rounds toward −∞.
  - sat clamps to [−2^(DW−1), 2^(DW−1)−1].
- Outputs hold their value until overwritten in STORE. Neurons already stored keep their new values while later neurons are still computing.
- Simultaneous wr_en and start in IDLE: the write commits on the same edge, and the computation uses the new value.
- start while busy: ignored.
- reset mid-operation: IDLE on that edge, no done pulse, outputs cleared.

## Timing
- Latency: done is high in the cycle beginning N_OUT*(N_IN+1)+1 edges after the edge that sampled start. Defaults: 15.
- busy rises on the edge after start is sampled and falls on the edge that leaves DONE. busy is high during the done cycle.
- Back-to-back operation: start can be accepted on the edge ending DONE+1, i.e. the first IDLE cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- MLP_LAYER_RELU_EN defined: STORE writes max(0, sat(acc>>>FRAC)), so negative results become 0.
- MLP_LAYER_RELU_EN undefined: linear output, and negative saturated results pass unchanged.
- Timing is identical in both modes.

## Test plan
- Reset: hold reset 10 cycles with random inputs → busy=0, done=0, out_flat=0. A start with an unloaded memory gives all outputs 0 at edge 15.
- Basic (defaults):
  - Stimulus: x0..x5 = 0x00010000..0x00060000. Neuron 0: all weights 0x00010000, bias 0. Neuron 1: w[1][0]=0x00008000, rest 0, bias 0xFFFF0000.
  - Response: done at edge 15, y0=0x00150000, y1=0xFFFF8000. With MLP_LAYER_RELU_EN, y1=0x00000000.
- Saturation: all x and all w = 0x7FFF0000, biases 0 → y0=y1=0x7FFFFFFF. With all w = 0x80010000 → y=0x80000000, or 0 under ReLU.
- Reset mid-op: assert reset at edge 5 after start → no done pulse, busy=0, out_flat=0 on the next cycle.
- Busy protection:
  - Stimulus: during busy, write w[0][0]=0 and re-pulse start.
  - Response: exactly one done pulse, with results as in the basic case. After done, read-back via a new run shows the weight is unchanged.
- Write+start same edge: in IDLE, write b[0]=0x00020000 with start=1 → y0=0x00170000.
